getir2: RTL

- Second fetch stage; sits directly downstream of getir1 and upstream of the decode stage (coz).
- Receives the program counter (PS) of every instruction request that getir1 issued to L1B, and pairs each L1B instruction response with its PS in issue order.
- Buffers paired (PS, instruction) results and hands them to coz over a valid/ready handshake.
- Discards in-flight responses that belong to a flushed path.

---
 rtl/getir2_pkg.sv | 23 ++
 rtl/getir2_if.sv | 36 +++
 rtl/getir2_fifo.sv | 43 ++++
 rtl/getir2.sv | 103 ++++++++++
 4 files changed

// File: rtl/getir2_pkg.sv
// Shared constants for the fetch pipeline and a helper for counter sizing.
package getir2_pkg;

  localparam int PS_BIT     = 32;
  localparam int BUYRUK_BIT = 32;

  localparam logic [PS_BIT-1:0] BELLEK_BASLANGIC = 32'h4000_0000;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // A (PS, instruction) pair as handed to decode.
  typedef struct packed {
    logic [PS_BIT-1:0]     ps;
    logic [BUYRUK_BIT-1:0] buyruk;
  } cift_t;

  // Bits needed to hold a count of 0..n.
  function automatic int sayac_bit(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/getir2_if.sv
// Bundle of the getir1 -> getir2, L1B -> getir2 and getir2 -> coz signals.
interface getir2_if #(
  parameter int PS_BIT     = getir2_pkg::PS_BIT,
  parameter int BUYRUK_BIT = getir2_pkg::BUYRUK_BIT
);

  logic [PS_BIT-1:0]     g2_ps_i;
  logic                  g2_ps_gecerli_i;
  logic                  g2_ps_hazir_o;
  logic                  g2_istek_yapildi_i;
  logic [BUYRUK_BIT-1:0] l1b_buyruk_i;
  logic                  l1b_buyruk_gecerli_i;
  logic                  l1b_buyruk_hazir_o;
  logic [PS_BIT-1:0]     coz_ps_o;
  logic [BUYRUK_BIT-1:0] coz_buyruk_o;
  logic                  coz_gecerli_o;
  logic                  coz_hazir_i;
  logic                  cek_bosalt_i;

  modport slave (
    input  g2_ps_i, g2_ps_gecerli_i, g2_istek_yapildi_i,
    input  l1b_buyruk_i, l1b_buyruk_gecerli_i,
    input  coz_hazir_i, cek_bosalt_i,
    output g2_ps_hazir_o, l1b_buyruk_hazir_o,
    output coz_ps_o, coz_buyruk_o, coz_gecerli_o
  );

  modport master (
    output g2_ps_i, g2_ps_gecerli_i, g2_istek_yapildi_i,
    output l1b_buyruk_i, l1b_buyruk_gecerli_i,
    output coz_hazir_i, cek_bosalt_i,
    input  g2_ps_hazir_o, l1b_buyruk_hazir_o,
    input  coz_ps_o, coz_buyruk_o, coz_gecerli_o
  );

endinterface

// File: rtl/getir2_fifo.sv
// Small synchronous FIFO with a one-cycle clear; head data is combinational.
module getir2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone mark valid entries.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/getir2.sv
// Second fetch stage: pairs L1B responses with issued PCs in order and
// feeds decode, discarding responses that belong to a flushed path.
module getir2 #(
  parameter int PS_BIT         = getir2_pkg::PS_BIT,
  parameter int BUYRUK_BIT     = getir2_pkg::BUYRUK_BIT,
  parameter int PS_DERINLIK    = 2,
  parameter int CIKIS_DERINLIK = 2,
  parameter int MAX_BEKLEYEN   = 4
) (
  input logic     clk_i,
  input logic     rstn_i,
  getir2_if.slave bus
);

  import getir2_pkg::*;

  localparam int CNT_W = sayac_bit(MAX_BEKLEYEN);
  localparam int OUT_W = PS_BIT + BUYRUK_BIT;

  logic              flush;
  logic              ps_full, ps_empty, ps_push, ps_pop;
  logic [PS_BIT-1:0] ps_head, eslesen_ps;
  logic              out_full, out_empty, out_push, out_pop;
  logic [OUT_W-1:0]  out_head;
  logic              l1b_hazir, kabul, eslesme, atma_var, coz_gecerli;
  logic [CNT_W-1:0]  bekleyen_r, atilacak_r, bekleyen_d, atilacak_d;

  assign flush    = bus.cek_bosalt_i;
  assign atma_var = (atilacak_r != '0);

  assign l1b_hazir = atma_var || (!out_full && (!ps_empty || bus.g2_ps_gecerli_i));
  assign kabul     = bus.l1b_buyruk_gecerli_i && l1b_hazir;
  assign eslesme   = kabul && !atma_var && !flush;

  // With an empty queue the incoming PS pairs directly and must not also be queued.
  assign ps_pop     = eslesme && !ps_empty;
  assign ps_push    = bus.g2_ps_gecerli_i && !ps_full && !flush && !(eslesme && ps_empty);
  assign eslesen_ps = ps_empty ? bus.g2_ps_i : ps_head;

  assign out_push    = eslesme;
  assign coz_gecerli = !out_empty && !flush;
  assign out_pop     = coz_gecerli && bus.coz_hazir_i;

  getir2_fifo #(.WIDTH(PS_BIT), .DEPTH(PS_DERINLIK)) u_ps_kuyruk (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (flush),
    .push   (ps_push),
    .pop    (ps_pop),
    .data   (bus.g2_ps_i),
    .full   (ps_full),
    .empty  (ps_empty),
    .head   (ps_head)
  );

  getir2_fifo #(.WIDTH(OUT_W), .DEPTH(CIKIS_DERINLIK)) u_cikis (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (flush),
    .push   (out_push),
    .pop    (out_pop),
    .data   ({eslesen_ps, bus.l1b_buyruk_i}),
    .full   (out_full),
    .empty  (out_empty),
    .head   (out_head)
  );

  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    bekleyen_d = bekleyen_r;
    atilacak_d = atilacak_r;
    if (flush) begin
      // Everything still in flight is old path; the request made now is new path.
      atilacak_d = atilacak_r + bekleyen_r - CNT_W'(kabul);
      bekleyen_d = CNT_W'(bus.g2_istek_yapildi_i);
    end else begin
      bekleyen_d = bekleyen_r + CNT_W'(bus.g2_istek_yapildi_i) - CNT_W'(eslesme);
      if (kabul && atma_var) atilacak_d = atilacak_r - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      bekleyen_r <= '0;
      atilacak_r <= '0;
    end else begin
      bekleyen_r <= bekleyen_d;
      atilacak_r <= atilacak_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i && !flush)
      assert (!(bus.g2_istek_yapildi_i && !eslesme && bekleyen_r == CNT_W'(MAX_BEKLEYEN)));
  end

  assign bus.g2_ps_hazir_o      = !ps_full;
  assign bus.l1b_buyruk_hazir_o = l1b_hazir;
  assign bus.coz_gecerli_o      = coz_gecerli;
  assign bus.coz_ps_o           = out_empty ? '0 : out_head[OUT_W-1 -: PS_BIT];
  assign bus.coz_buyruk_o       = out_empty ? '0 : out_head[BUYRUK_BIT-1:0];

endmodule
